// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Holds the state encoding, the result encoding and the parameter legality check.
package cmp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SCAN = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Result vector ordering is {lt, eq, gt}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  function automatic bit params_ok(input int unsigned width, input int unsigned digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/seq_magnitude_compare_if.sv
// Start/done handshake and operand/result bundle for seq_magnitude_compare.
// The master issues compares; the slave (comparator) returns busy/done/lt/eq/gt.
interface seq_magnitude_compare_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/lt_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module lt_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_lt_c,
  output logic             o_gt_c
);
  assign o_lt_c = (i_a < i_b);
  assign o_gt_c = (i_a > i_b);
endmodule

// File: rtl/seq_magnitude_compare.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle with early exit.
// Signed mode flips both sign bits at accept so one unsigned datapath serves both modes.
module seq_magnitude_compare
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_magnitude_compare_if.slave bus
);
  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("seq_magnitude_compare: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [2:0]       r_res, w_res_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [DIGIT-1:0] w_a_dig, w_b_dig;
  logic             w_lt, w_gt;

  // Digit mux: digit k sits at [WIDTH-1-k*DIGIT -: DIGIT]
  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_dig = r_a[WIDTH-1-i*DIGIT -: DIGIT];
        w_b_dig = r_b[WIDTH-1-i*DIGIT -: DIGIT];
      end
    end
  end

  lt_digit #(.DIGIT(DIGIT)) u_lt_digit (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .o_lt_c (w_lt),
    .o_gt_c (w_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= RES_NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_res   <= w_res_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_res_nxt   = r_res;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_nxt            = bus.a;
          w_b_nxt            = bus.b;
          w_a_nxt[WIDTH-1]   = bus.a[WIDTH-1] ^ bus.signed_mode;
          w_b_nxt[WIDTH-1]   = bus.b[WIDTH-1] ^ bus.signed_mode;
          w_idx_nxt          = '0;
          w_res_nxt          = RES_NONE;
          w_busy_nxt         = 1'b1;
          w_state_nxt        = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_lt) begin
          w_res_nxt   = RES_LT;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_gt) begin
          w_res_nxt   = RES_GT;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_idx == LAST) begin
          w_res_nxt   = RES_EQ;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.lt   = r_res[2];
  assign bus.eq   = r_res[1];
  assign bus.gt   = r_res[0];

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Directed bench for seq_magnitude_compare (WIDTH=32, DIGIT=2) with an expected-result queue.
module tb_seq_magnitude_compare;
  localparam int WIDTH = 32;
  localparam int DIGIT = 2;
  localparam int N     = WIDTH / DIGIT;

  typedef struct packed {
    logic [2:0] res;
    logic [7:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_magnitude_compare_if #(.WIDTH(WIDTH)) bus ();

  seq_magnitude_compare #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result from native compares; latency from the highest differing bit position
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sm);
    exp_t        e;
    logic [31:0] x;
    int          p;
    x = a ^ b;
    if (a == b)                             e.res = 3'b010;
    else if (sm ? ($signed(a) < $signed(b)) : (a < b)) e.res = 3'b100;
    else                                    e.res = 3'b001;
    if (x == 32'd0) begin
      e.cyc = 8'(N + 1);
    end else begin
      p = 0;
      for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
      e.cyc = 8'(((WIDTH - 1 - p) / DIGIT) + 2);
    end
    return e;
  endfunction

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic sm, input int pulse_cyc, input int abort_cyc);
    exp_t e;
    int   cyc;
    bit   busy_ok;
    bit   seen;
    sb.push_back(model(a, b, sm));
    @(negedge clk);
    bus.a = a; bus.b = b; bus.signed_mode = sm; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~a; bus.b = a; bus.signed_mode = ~sm;
    cyc = 1; busy_ok = 1'b1; seen = 1'b0;
    while (cyc <= 40) begin
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        check({tag, " reset outs"}, 32'({bus.busy, bus.done, bus.lt, bus.eq, bus.gt}), 32'd0);
        void'(sb.pop_front());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, " idle after reset"}, 32'({bus.busy, bus.done, bus.lt, bus.eq, bus.gt}), 32'd0);
        return;
      end
      if (pulse_cyc > 0 && cyc == pulse_cyc) begin
        bus.a = 32'd9; bus.b = 32'd1; bus.start = 1'b1;
      end
      if (pulse_cyc > 0 && cyc == pulse_cyc + 1) bus.start = 1'b0;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " done cycle"}, 32'(cyc), 32'(e.cyc));
    check({tag, " result"}, 32'({bus.lt, bus.eq, bus.gt}), 32'(e.res));
    check({tag, " busy held"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({tag, " after done"}, 32'({bus.busy, bus.done, bus.lt, bus.eq, bus.gt}),
          32'({2'b00, e.res}));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("reset state", 32'({bus.busy, bus.done, bus.lt, bus.eq, bus.gt}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("u 5<9",         32'd5,          32'd9,          1'b0, 0, 0);
    run("u eq deadbeef", 32'hDEADBEEF,   32'hDEADBEEF,   1'b0, 0, 0);
    run("s eq deadbeef", 32'hDEADBEEF,   32'hDEADBEEF,   1'b1, 0, 0);
    run("u ffff vs 1",   32'hFFFFFFFF,   32'h00000001,   1'b0, 0, 0);
    run("s ffff vs 1",   32'hFFFFFFFF,   32'h00000001,   1'b1, 0, 0);
    run("u 8000 vs 7fff", 32'h80000000,  32'h7FFFFFFF,   1'b0, 0, 0);
    run("s 8000 vs 7fff", 32'h80000000,  32'h7FFFFFFF,   1'b1, 0, 0);
    run("busy start ignored", 32'd3,     32'd3,          1'b0, 5, 0);
    run("reset abort",   32'd0,          32'd0,          1'b0, 0, 8);
    run("u 1<2 after reset", 32'd1,      32'd2,          1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 2) ? ra : ($urandom ^ (32'h1 << $urandom_range(0, 31)));
      rs = 1'($urandom_range(0, 1));
      run("random", ra, rb, rs, 0, 0);
    end

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_compare.md
# seq_magnitude_compare

Multi-cycle, parametrised magnitude comparator. It is the sequential successor to our single-cycle bit-sliced less-than cells. It scans two WIDTH-bit operands MSB-first, DIGIT bits per cycle, and terminates early on the first differing digit. It supports unsigned and two's-complement signed modes and reports lt/eq/gt through a start/done handshake. It sits beside the ALU as the compare/branch-condition engine, where a full-width single-cycle compare would not meet timing.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- N (localparam), WIDTH/DIGIT, number of digits. Digit 0 is the MSB digit, [WIDTH-1 -: DIGIT].

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a compare; accepted only in IDLE.
- signed_mode  in  1  1 = two's-complement compare; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse when a result becomes valid.
- lt  out  1  A < B.
- eq  out  1  A == B.
- gt  out  1  A > B.

## Operation
- States:
  - IDLE → SCAN when start is sampled high.
  - SCAN → DONE on the first differing digit, or after digit N-1 compares equal.
  - DONE → IDLE unconditionally.
- Accept (IDLE and start=1):
  - Latch a and b into internal operand registers.
  - If signed_mode=1, invert bit WIDTH-1 of both latched operands. Signed order then maps onto unsigned order.
  - Clear the digit index to 0.
  - Clear lt, eq and gt to 0.
- SCAN, one digit per cycle at the current index k, using an unsigned DIGIT-bit compare:
  - If A_k < B_k: set lt, enter DONE.
  - If A_k > B_k: set gt, enter DONE.
  - If equal and k = N-1: set eq, enter DONE.
  - Otherwise k increments.
- DONE: done=1 for exactly one cycle.
- lt/eq/gt hold their value until the next accepted start. After any completion exactly one of them is 1.
- start while busy=1 is ignored. Changes on a, b or signed_mode after acceptance have no effect.
- The digit index is ceil(log2 N) bits wide and never exceeds N-1. No wrap-around occurs.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, lt=0, eq=0, gt=0, index=0.
- Reset asserted mid-SCAN or in DONE aborts immediately. No done pulse is produced.
- Cycle numbering: start is sampled at edge E0, so cycle 1 follows E0.
- Digit k is compared in cycle k+1.
- First difference at digit k: done, and the valid result, appear in cycle k+2.
- Equal operands: done in cycle N+1 (worst case). Best case: done in cycle 2.
- busy rises in cycle 1 and falls in the cycle after done. The earliest next start is accepted in that cycle, so the minimum issue interval is k+3 cycles.
- lt/eq/gt are registered. They change only at accept (to 0) and at the DONE entry edge.

## Structure
- Shared package (cmp_pkg):
  - State typedef (IDLE/SCAN/DONE).
  - Result encoding constants.
  - Parameter legality check (WIDTH % DIGIT == 0).
- One sub-module, lt_digit: a combinational DIGIT-bit unsigned compare producing lt and gt.
- The top level holds the FSM, operand registers, sign-flip, digit mux and index counter.

## Test plan
WIDTH=32, DIGIT=2, N=16. Cycle numbers are counted from the start sample.
- Unsigned a=5, b=9: digits differ at k=14 → lt=1, eq=0, gt=0, done in cycle 16.
- a=b=0xDEADBEEF, either mode → eq=1, done in cycle 17, busy high for cycles 1–17.
- a=0xFFFFFFFF, b=0x00000001: unsigned → gt=1; signed → lt=1; both with done in cycle 2.
- a=0x80000000, b=0x7FFFFFFF: unsigned → gt=1; signed → lt=1; done in cycle 2.
- Accept a=3, b=3. Pulse start with a=9, b=1 in cycle 5 (busy) → second request ignored; eq=1 in cycle 17; new start accepted only once busy=0.
- Start a=b=0, drop rst_n in cycle 8 → busy, done, lt, eq and gt are 0 immediately, with no done pulse. After release, a=1, b=2 → lt=1 in cycle 17.
